axi_lite_master: RTL and testbench

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_spy_pkg.sv | 19 +
 rtl/axi_lite_master.sv | 200 ++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_spy_pkg.sv
// Shared definitions for the AXI4-Lite single-transaction master.
// Holds the transaction FSM state encoding and the AXI response codes.
package axi_spy_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WAIT_B       = 3'd2,
        RD_ADDR      = 3'd3,
        WAIT_R       = 3'd4,
        RESP         = 3'd5
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite master that turns one command at a time into a single AXI
// read or write and returns the captured response.
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready only while idle)
//   cmd_write/addr/wdata   command fields, latched on acceptance
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata/rsp_resp     read data (0 for writes) and BRESP/RRESP
//   AW*/W*/B*/AR*/R*       AXI4-Lite master channels
//
// Every VALID/READY output is a flop loaded from the next state, so no
// output has a combinational path from an AXI input.
module axi_lite_master
    import axi_spy_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic [1:0]            BRESP,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP
);

    state_e                state_r;
    state_e                state_s;
    logic                  aw_done_r;
    logic                  aw_done_s;
    logic                  w_done_r;
    logic                  w_done_s;
    logic                  cmd_ready_r;
    logic                  awvalid_r;
    logic                  wvalid_r;
    logic                  bready_r;
    logic                  arvalid_r;
    logic                  rready_r;
    logic                  rsp_valid_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic [1:0]            rsp_resp_r;
    logic                  cmd_hs_s;
    logic                  b_hs_s;
    logic                  r_hs_s;

    // Handshake strobes, qualified with our own registered VALID/READY.
    always_comb begin
        cmd_hs_s = (state_r == IDLE) && cmd_valid && cmd_ready_r;
        b_hs_s   = (state_r == WAIT_B) && BVALID && bready_r;
        r_hs_s   = (state_r == WAIT_R) && RVALID && rready_r;
    end

    // Next-state logic; AW and W completion are tracked independently.
    always_comb begin
        state_s   = state_r;
        aw_done_s = aw_done_r;
        w_done_s  = w_done_r;
        case (state_r)
            IDLE: begin
                aw_done_s = 1'b0;
                w_done_s  = 1'b0;
                if (cmd_hs_s) begin
                    state_s = cmd_write ? WR_ADDR_DATA : RD_ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_ADDR_DATA: begin
                aw_done_s = aw_done_r || (awvalid_r && AWREADY);
                w_done_s  = w_done_r  || (wvalid_r && WREADY);
                if (aw_done_s && w_done_s) begin
                    state_s = WAIT_B;
                end else begin
                    state_s = WR_ADDR_DATA;
                end
            end
            WAIT_B: begin
                if (b_hs_s) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT_B;
                end
            end
            RD_ADDR: begin
                if (arvalid_r && ARREADY) begin
                    state_s = WAIT_R;
                end else begin
                    state_s = RD_ADDR;
                end
            end
            WAIT_R: begin
                if (r_hs_s) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT_R;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s   = IDLE;
                aw_done_s = 1'b0;
                w_done_s  = 1'b0;
            end
        endcase
    end

    // State and handshake flags; outputs are loaded from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            cmd_ready_r <= 1'b0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            aw_done_r   <= aw_done_s;
            w_done_r    <= w_done_s;
            cmd_ready_r <= (state_s == IDLE);
            awvalid_r   <= (state_s == WR_ADDR_DATA) && !aw_done_s;
            wvalid_r    <= (state_s == WR_ADDR_DATA) && !w_done_s;
            bready_r    <= (state_s == WAIT_B);
            arvalid_r   <= (state_s == RD_ADDR);
            rready_r    <= (state_s == WAIT_R);
            rsp_valid_r <= (state_s == RESP);
        end
    end

    // Command latch and response capture; held stable between events.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r      <= {ADDR_WIDTH{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_resp_r  <= 2'b00;
        end else begin
            if (cmd_hs_s) begin
                addr_r  <= cmd_addr;
                wdata_r <= cmd_wdata;
            end
            if (b_hs_s) begin
                rsp_rdata_r <= {DATA_WIDTH{1'b0}};
                rsp_resp_r  <= BRESP;
            end else if (r_hs_s) begin
                rsp_rdata_r <= RDATA;
                rsp_resp_r  <= RRESP;
            end
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_resp  = rsp_resp_r;
    assign AWVALID   = awvalid_r;
    assign AWADDR    = addr_r;
    assign WVALID    = wvalid_r;
    assign WDATA     = wdata_r;
    assign BREADY    = bready_r;
    assign ARVALID   = arvalid_r;
    assign ARADDR    = addr_r;
    assign RREADY    = rready_r;

endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboard bench for axi_lite_master: directed commands push expected
// responses; a negedge monitor pops and compares them and also checks
// channel addresses/data, VALID hold lengths, latency and reset behaviour.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
    logic [31:0] AWADDR, WDATA, ARADDR;
    logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;
    logic [31:0] RDATA = 32'h0;

    axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          lat;
        int          hold;
    } exp_t;
    exp_t exp_q[$];

    // slave configuration and current transaction, set by the stimulus
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = 32'h0;
    logic [31:0] cur_addr = 32'h0, cur_wdata = 32'h0;
    logic        done = 1'b0;

    // monitor-owned state
    int          errors = 0, checks = 0;
    int          cyc = 0, acc_cyc = 0, wd = 0;
    int          aw_run = 0, w_run = 0, ar_run = 0, hold_cnt = 0;
    int          aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, r_hs_cnt = 0;
    logic        aw_seen = 1'b0, w_seen = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic        rst_prev = 1'b0, rst_prev2 = 1'b0;
    logic        rsp_active = 1'b0, stable = 1'b1, busy_ok = 1'b1;
    logic [31:0] snap_rdata = 32'h0;
    logic [1:0]  snap_resp = 2'b00;
    exp_t        e;

    // slave-side counters
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;

    // AXI slave model: READY/VALID after a configurable number of cycles.
    always @(posedge clk) begin
        #1;
        if (AWVALID) begin AWREADY = (aw_wait >= aw_dly); aw_wait++; end
        else begin AWREADY = 1'b0; aw_wait = 0; end
        if (WVALID) begin WREADY = (w_wait >= w_dly); w_wait++; end
        else begin WREADY = 1'b0; w_wait = 0; end
        if (ARVALID) begin ARREADY = (ar_wait >= ar_dly); ar_wait++; end
        else begin ARREADY = 1'b0; ar_wait = 0; end
        if (b_pend) begin BVALID = (b_wait >= b_dly); b_wait++; end
        else begin BVALID = 1'b0; b_wait = 0; end
        if (r_pend) begin RVALID = (r_wait >= r_dly); r_wait++; end
        else begin RVALID = 1'b0; r_wait = 0; end
        BRESP = bresp_cfg;
        RRESP = rresp_cfg;
        RDATA = rdata_cfg;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor / scoreboard: samples everything mid-cycle on the negedge.
    always @(negedge clk) begin
        cyc++;
        if (rst_prev) begin
            chk("reset_ctrl", {cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 128'h0);
            chk("reset_data", {rsp_rdata, rsp_resp, AWADDR, WDATA}, 128'h0);
        end
        if (rst_prev2 && !rst_prev) chk("cmd_ready_after_reset", cmd_ready, 128'h1);
        if (reset) begin
            aw_seen = 1'b0; w_seen = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
            aw_run = 0; w_run = 0; ar_run = 0; rsp_active = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (AWVALID) aw_run++;
            if (WVALID) w_run++;
            if (ARVALID) ar_run++;
            if (AWVALID && AWREADY) begin
                chk("awaddr", AWADDR, cur_addr);
                chk("awvalid_len", aw_run, aw_dly + 1);
                aw_run = 0; aw_seen = 1'b1; aw_hs_cnt++;
            end
            if (WVALID && WREADY) begin
                chk("wdata", WDATA, cur_wdata);
                chk("wvalid_len", w_run, w_dly + 1);
                w_run = 0; w_seen = 1'b1; w_hs_cnt++;
            end
            if (aw_seen && w_seen) begin b_pend = 1'b1; aw_seen = 1'b0; w_seen = 1'b0; end
            if (BVALID && BREADY) begin b_pend = 1'b0; b_hs_cnt++; end
            if (ARVALID && ARREADY) begin
                chk("araddr", ARADDR, cur_addr);
                chk("arvalid_len", ar_run, ar_dly + 1);
                ar_run = 0; r_pend = 1'b1; ar_hs_cnt++;
            end
            if (RVALID && RREADY) begin r_pend = 1'b0; r_hs_cnt++; end
            if (rsp_valid) begin
                if (!rsp_active) begin
                    rsp_active = 1'b1; hold_cnt = 0; stable = 1'b1; busy_ok = 1'b1;
                    snap_rdata = rsp_rdata; snap_resp = rsp_resp;
                end
                hold_cnt++;
                if (rsp_rdata !== snap_rdata || rsp_resp !== snap_resp) stable = 1'b0;
                if (cmd_ready !== 1'b0) busy_ok = 1'b0;
                if (rsp_ready) begin
                    rsp_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp_unexpected: actual rdata=%0h resp=%0h required no response", rsp_rdata, rsp_resp);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_resp", rsp_resp, e.resp);
                        if (e.lat >= 0) chk("rsp_latency", cyc - acc_cyc, e.lat);
                        if (e.hold >= 0) chk("rsp_hold", hold_cnt, e.hold);
                        chk("rsp_stable", stable, 128'h1);
                        chk("cmd_ready_low_in_resp", busy_ok, 128'h1);
                    end
                end
            end
            if (exp_q.size() != 0) wd++; else wd = 0;
            if (wd > 500) begin
                checks++; errors++;
                $display("FAIL rsp_timeout: actual=no response required=%0d pending", exp_q.size());
                exp_q.delete(); wd = 0;
            end
        end
        rst_prev2 = rst_prev;
        rst_prev  = reset;
        if (done) begin
            chk("aw_count", aw_hs_cnt, 128'd3);
            chk("w_count", w_hs_cnt, 128'd3);
            chk("b_count", b_hs_cnt, 128'd3);
            chk("ar_count", ar_hs_cnt, 128'd3);
            chk("r_count", r_hs_cnt, 128'd3);
            chk("queue_empty", exp_q.size(), 128'd0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic push, input logic [31:0] erd, input logic [1:0] ers,
                         input int lat, input int hold);
        exp_t x;
        cur_addr = a; cur_wdata = d;
        if (push) begin
            x.rdata = erd; x.resp = ers; x.lat = lat; x.hold = hold;
            exp_q.push_back(x);
        end
        @(posedge clk); #2;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        @(posedge clk); #2;
        cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = ~d;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && cmd_ready) break;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);

        // 1: write, slave always ready, OKAY -> response in cycle 3
        issue(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 32'h0, 2'b00, 3, 1);
        wait_done();

        // 2: AWREADY delayed 3 cycles, WREADY immediate
        aw_dly = 3;
        issue(1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 1'b1, 32'h0, 2'b00, 6, 1);
        wait_done();
        aw_dly = 0;

        // 3: read with RVALID after a 5-cycle gap
        r_dly = 5; rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b00;
        issue(1'b0, 32'h0000_2004, 32'h0, 1'b1, 32'h1234_5678, 2'b00, 8, 1);
        wait_done();
        r_dly = 0;

        // 4: SLVERR read with rsp_ready held low 4 cycles
        rdata_cfg = 32'hCAFE_F00D; rresp_cfg = 2'b10; rsp_ready = 1'b0;
        issue(1'b0, 32'h0000_3000, 32'h0, 1'b1, 32'hCAFE_F00D, 2'b10, 7, 5);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        repeat (4) @(posedge clk);
        #2 rsp_ready = 1'b1;
        wait_done();

        // 5: write after a read (rdata must clear), W late, B late, DECERR
        w_dly = 2; b_dly = 1; bresp_cfg = 2'b11;
        issue(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1, 32'h0, 2'b11, 6, 1);
        wait_done();
        w_dly = 0; b_dly = 0; bresp_cfg = 2'b00;

        // reset while ARVALID waits on ARREADY: transaction abandoned
        ar_dly = 100;
        issue(1'b0, 32'h0000_5000, 32'h0, 1'b0, 32'h0, 2'b00, -1, -1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        ar_dly = 0;

        // 6: read after reset, EXOKAY, full-speed slave
        rdata_cfg = 32'h0000_0001; rresp_cfg = 2'b01;
        issue(1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0000_0001, 2'b01, 3, 1);
        wait_done();

        repeat (4) @(posedge clk);
        done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=still running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
